// File: rtl/rsa_ctrl_q.sv
// Queued RSA controller: derives keys once, then serves tagged encrypt/decrypt jobs.
// Define RSA_CTRL_RANGE_CHECK_EN to reject messages >= n with rsp_err.

module inverter #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    output logic               finish,
    output logic [2*WIDTH-1:0] e,
    output logic [2*WIDTH-1:0] d
);
    localparam int MW = 2 * WIDTH;
    localparam logic [MW-1:0] ONE = MW'(1);
    localparam logic [MW-1:0] TWO = MW'(2);
    localparam logic [MW-1:0] THREE = MW'(3);

    logic [MW-1:0] phi, cand, r0, r1, qt;
    logic signed [MW+1:0] t0, t1, t0_fix;

    assign phi = (MW'(p) - ONE) * (MW'(q) - ONE);
    assign qt = (r1 == '0) ? '0 : r0 / r1;
    assign t0_fix = (t0 < 0) ? t0 + $signed({2'b00, phi}) : t0;

    // Extended Euclid on (phi, cand); t tracks the coefficient of cand.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= THREE;
            r0 <= phi;
            r1 <= THREE;
            t0 <= '0;
            t1 <= 1;
            finish <= 1'b0;
            e <= '0;
            d <= '0;
        end else if (!finish) begin
            if (r1 != '0) begin
                r0 <= r1;
                r1 <= r0 - qt * r1;
                t0 <= t1;
                t1 <= t0 - $signed({2'b00, qt}) * t1;
            end else if (r0 == ONE) begin
                finish <= 1'b1;
                e <= cand;
                d <= t0_fix[MW-1:0];
            end else begin
                cand <= cand + TWO;
                r0 <= phi;
                r1 <= cand + TWO;
                t0 <= '0;
                t1 <= 1;
            end
        end
    end
endmodule

module mod_exp #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] base,
    input  logic [2*WIDTH-1:0] exponent,
    input  logic [2*WIDTH-1:0] modulus,
    output logic               finish,
    output logic [2*WIDTH-1:0] result
);
    localparam int MW = 2 * WIDTH;
    localparam logic [MW-1:0] ONE = MW'(1);

    logic [MW-1:0] b, x, m;
    logic [2*MW-1:0] rb, bb;

    assign m = (modulus == '0) ? ONE : modulus;
    assign rb = ({{MW{1'b0}}, result} * {{MW{1'b0}}, b})
              % {{MW{1'b0}}, m};
    assign bb = ({{MW{1'b0}}, b} * {{MW{1'b0}}, b})
              % {{MW{1'b0}}, m};

    always_ff @(posedge clk) begin
        if (reset) begin
            b <= base % m;
            x <= exponent;
            result <= ONE % m;
            finish <= 1'b0;
        end else if (!finish) begin
            if (x != '0) begin
                if (x[0]) result <= rb[MW-1:0];
                b <= bb[MW-1:0];
                x <= x >> 1;
            end else begin
                finish <= 1'b1;
            end
        end
    end
endmodule

module rsa_ctrl_q #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_load,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    output logic               key_ready,
    output logic [2*WIDTH-1:0] pub_e,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_mode,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [2*WIDTH-1:0] req_msg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_msg,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               rsp_err,
    output logic               busy
);
    localparam int MW = 2 * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] QFULL = (AW+1)'(DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] KEYGEN    = 3'd1;
    localparam logic [2:0] KEYWAIT   = 3'd2;
    localparam logic [2:0] POP       = 3'd3;
    localparam logic [2:0] EXP_START = 3'd4;
    localparam logic [2:0] EXP_WAIT  = 3'd5;
    localparam logic [2:0] RESP      = 3'd6;

    logic [2:0] state;
    logic pend, skip;
    logic [WIDTH-1:0] kp, kq;
    logic [MW-1:0] n, key_e, key_d;
    logic [MW-1:0] msg_r, exp_r, mod_r;
    logic inv_fin, exp_fin, inv_rst, exp_rst;
    logic [MW-1:0] inv_e, inv_d, exp_res;

    logic mode_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [MW-1:0] msg_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop;

`ifdef RSA_CTRL_RANGE_CHECK_EN
    logic err_r;
    assign rsp_err = err_r;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = !reset && (count != QFULL);
    assign push = req_valid && req_ready;
    assign pop = (state == POP);
    assign busy = (state != IDLE);
    assign pub_e = key_e;
    assign inv_rst = reset || (state == KEYGEN);
    assign exp_rst = reset || (state == EXP_START);

    inverter #(.WIDTH(WIDTH)) u_inv (
        .clk(clk), .reset(inv_rst), .p(kp), .q(kq),
        .finish(inv_fin), .e(inv_e), .d(inv_d)
    );

    mod_exp #(.WIDTH(WIDTH)) u_exp (
        .clk(clk), .reset(exp_rst), .base(msg_r),
        .exponent(exp_r), .modulus(mod_r),
        .finish(exp_fin), .result(exp_res)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mode_q[wr_ptr] <= req_mode;
            tag_q[wr_ptr] <= req_tag;
            msg_q[wr_ptr] <= req_msg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1;
            if (pop) rd_ptr <= rd_ptr + 1;
            if (push && !pop) count <= count + 1;
            else if (pop && !push) count <= count - 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pend <= 1'b0;
            skip <= 1'b0;
            key_ready <= 1'b0;
            kp <= '0;
            kq <= '0;
            n <= '0;
            key_e <= '0;
            key_d <= '0;
            msg_r <= '0;
            exp_r <= '0;
            mod_r <= '0;
            rsp_valid <= 1'b0;
            rsp_msg <= '0;
            rsp_tag <= '0;
`ifdef RSA_CTRL_RANGE_CHECK_EN
            err_r <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pend) state <= KEYGEN;
                    else if (key_ready && (count != '0 || push))
                        state <= POP;
                end
                KEYGEN: begin
                    n <= MW'(kp) * MW'(kq);
                    state <= KEYWAIT;
                end
                KEYWAIT: begin
                    if (!skip && inv_fin) begin
                        key_e <= inv_e;
                        key_d <= inv_d;
                        key_ready <= 1'b1;
                        pend <= 1'b0;
                        state <= IDLE;
                    end
                end
                POP: begin
                    msg_r <= msg_q[rd_ptr];
                    exp_r <= mode_q[rd_ptr] ? key_e : key_d;
                    mod_r <= n;
                    rsp_tag <= tag_q[rd_ptr];
`ifdef RSA_CTRL_RANGE_CHECK_EN
                    err_r <= 1'b0;
                    if (msg_q[rd_ptr] >= n) begin
                        err_r <= 1'b1;
                        rsp_msg <= '0;
                        rsp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        state <= EXP_START;
                    end
`else
                    state <= EXP_START;
`endif
                end
                EXP_START: state <= EXP_WAIT;
                EXP_WAIT: begin
                    if (!skip && exp_fin) begin
                        rsp_msg <= exp_res;
                        rsp_valid <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            skip <= (state == KEYGEN) || (state == EXP_START);
            // A running exp job keeps its captured keys; keygen restarts only from IDLE or keygen itself.
            if (key_load) begin
                pend <= 1'b1;
                key_ready <= 1'b0;
                kp <= p;
                kq <= q;
                if (state == KEYGEN || state == KEYWAIT)
                    state <= KEYGEN;
            end
        end
    end
endmodule

// File: doc/rsa_ctrl_q.md
# rsa_ctrl_q

Queued, handshaked successor of the single-shot RSA control block. It accepts a key pair (p, q) and derives the exponents once, through the existing `inverter` submodule. It then serves a queue of up to DEPTH encrypt/decrypt requests, one at a time, through the existing `mod_exp` submodule. Each result is returned with its tag on a valid/ready response port.

## Interface
- WIDTH, 64: prime width; modulus, exponents and messages are 2*WIDTH bits
- DEPTH, 4: request queue entries; power of 2, ≥2
- TAG_W, 4: request tag width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- key_load  in  1  one-cycle pulse; latch p and q, then regenerate keys
- p, q  in  WIDTH  primes, sampled on key_load
- key_ready  out  1  keys valid; requests may execute
- pub_e  out  2*WIDTH  current public exponent (for checking)
- req_valid / req_ready  in / out  1  request handshake
- req_mode  in  1  1 = encrypt (uses e), 0 = decrypt (uses d)
- req_tag  in  TAG_W  opaque tag, returned unchanged
- req_msg  in  2*WIDTH  message or cipher
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_msg  out  2*WIDTH  result
- rsp_tag  out  TAG_W  tag of the request
- rsp_err  out  1  request rejected (see Configuration)
- busy  out  1  FSM not in IDLE

## Operation
- Reset values: key_ready, pub_e, rsp_valid, rsp_msg, rsp_tag, rsp_err and busy are 0. The queue is empty and n, e, d are 0. req_ready is 0 while reset is asserted and 1 afterwards.
- Submodule start: a job starts with a one-cycle reset pulse to the submodule. The submodule's finish output is ignored on the pulse cycle and the cycle after it. A completed job is then detected by finish high.
- Queue: FIFO of {mode, tag, msg}.
  - req_ready = !full, computed from the registered count only.
  - A push and a pop in the same cycle are allowed; the count is unchanged.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- key_load handling:
  - key_load sets a pending flag and clears key_ready in the next cycle.
  - p and q are latched in the same cycle.
  - A key_load that arrives during an exponentiation job waits until that job's response handshake completes.
  - A key_load during KEYGEN restarts keygen with the new p and q.
- FSM states:
  - IDLE: if key pending, go to KEYGEN. Else, if key_ready and the queue is not empty, go to POP.
  - KEYGEN: n <= p*q (2*WIDTH bits, full product); pulse inverter reset; go to KEYWAIT.
  - KEYWAIT: on inverter finish, latch e and d, set key_ready, update pub_e, clear pending; go to IDLE.
  - POP: dequeue the head into msg/mode/tag registers; exp_reg <= mode ? e : d; mod_reg <= n; go to EXP_START.
  - EXP_START: pulse mod_exp reset; go to EXP_WAIT.
  - EXP_WAIT: on mod_exp finish, capture the result into rsp_msg, set rsp_valid; go to RESP.
  - RESP: hold all rsp_* outputs stable until rsp_ready is high; then clear rsp_valid and go to IDLE.
- Requests stay queued while key_ready = 0. Keys are never changed under a running job.
- Reset in mid-operation: all state is cleared at once, including the queue. Queued requests are lost.

## Timing
- Request accepted at cycle t, with the queue empty, key_ready = 1 and the FSM in IDLE:
  - POP at t+1
  - EXP_START at t+2
  - EXP_WAIT from t+3
  - rsp_valid the cycle after finish is first seen high
- Back-to-back: the next POP comes one cycle after IDLE, i.e. 2 cycles after the response handshake.
- Keygen: key_ready rises the cycle after inverter finish.

## Configuration
- RSA_CTRL_RANGE_CHECK_EN:
  - Defined: in POP, a request with msg ≥ n skips exponentiation and goes directly to RESP with rsp_err = 1, rsp_msg = 0 and its tag.
  - Undefined: rsp_err is tied to 0 and every message is exponentiated; the result is taken modulo n.

## Test plan
- Reset check: WIDTH = 8. Assert reset mid-job with 3 requests queued → all outputs are 0, and after release req_ready = 1 and 3 new pushes are accepted.
- Encrypt/decrypt round trip: p = 61, q = 53. key_load, wait for key_ready (n = 3233). Encrypt msg 65 (tag 1) → rsp_msg = 65^pub_e mod 3233. Then decrypt that result (tag 2) → rsp_msg = 65, rsp_tag = 2.
- Queue full: push 5 requests with DEPTH = 4 and rsp_ready = 0 → the 5th is held off by req_ready = 0. Responses come back in order, tags 0..3.
- key_load during EXP_WAIT → the current response uses the old keys; key_ready drops; the next request executes only after the new keys are ready.
- Range check (macro defined): msg = 3233 → rsp_err = 1, rsp_msg = 0, no mod_exp start pulse. Macro undefined: the same message returns rsp_err = 0.
- Response backpressure: hold rsp_ready = 0 for 10 cycles → rsp_msg and rsp_tag stay stable, and no further pop happens.
